ov_frame_reader: RTL and testbench
==================================

Name: ov_frame_reader

Overview:
- Parametrised successor to the fixed-resolution OV7670 capture path.
- Controls an AL422-style camera frame FIFO: arms one full frame write between two VSYNC edges, then reads that frame out with a generated read clock.
- Packs bytes into 16-bit words in one of three runtime-selectable modes and pushes them into the SDRAM write FIFO, with almost-full back-pressure.
- Sits between the SCCB init sequencer (start_init/init_done handshake) and the SDRAM write-FIFO port.

Parameters:
- H_ACT, 640, active pixels per line; must be even.
- V_ACT, 480, active lines per frame; must be even.
- USEDW_W, 11, width of w_usedw.
- AFULL, 1000, read pauses while w_usedw >= AFULL.
- INIT_DLY, 1024, S_CLK cycles from reset release to the start_init pulse.
- WRST_CYC, 4, OV_wrst low-pulse length in S_CLK cycles.
- RRST_CYC, 4, number of OV_rclk periods with OV_rrst held low.
- VS_POL, 1, active level of OV_vsync; 1 means a frame starts on the rising edge.

Ports:
- S_CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- start_init  out  1  one-cycle pulse requesting SCCB configuration.
- init_done  in  1  high when sensor configuration is complete.
- mode  in  2  0=RGB565, 1=GRAY8 packed (Y of YUYV), 2=RGB565 decimated by 2; 3 is treated as 0.
- OV_data  in  8  camera FIFO read data.
- OV_vsync  in  1  sensor VSYNC (asynchronous).
- OV_wrst  out  1  camera FIFO write-pointer reset, active low.
- OV_rrst  out  1  camera FIFO read-pointer reset, active low.
- OV_oe  out  1  camera FIFO output enable, active low.
- OV_wen  out  1  camera FIFO write enable.
- OV_rclk  out  1  camera FIFO read clock.
- w_usedw  in  USEDW_W  SDRAM write-FIFO fill level.
- w_req  out  1  one-cycle write strobe.
- w_clk  out  1  equals S_CLK (forwarded, combinational).
- w_data  out  16  write data; valid while w_req=1.
- frame_done  out  1  one-cycle pulse after the last word of a frame.
- frame_cnt  out  16  number of completed frames; wraps.

Behaviour:
- Reset values: start_init=0, OV_wrst=1, OV_rrst=1, OV_oe=1, OV_wen=0, OV_rclk=0, w_req=0, w_data=0, frame_done=0, frame_cnt=0. The state machine returns to BOOT.
- Asserting RST_N low mid-frame aborts immediately. No partial frame is flushed.
- OV_vsync: 2-FF synchroniser, then edge detect. vs_start is a one-cycle pulse on the VS_POL-active edge.
- BOOT: count INIT_DLY cycles, pulse start_init for 1 cycle, go to WAIT_INIT.
- WAIT_INIT: wait for init_done=1, go to ARM. After leaving WAIT_INIT, init_done is ignored.
- ARM: on vs_start, latch mode into mode_q, drive OV_wrst=0 for WRST_CYC cycles, set OV_wen=1, go to WRITE.
- WRITE: on the next vs_start, clear OV_wen in the same cycle as the detected edge, go to RRST.
- RRST: drive OV_oe=0 and OV_rrst=0 while generating RRST_CYC OV_rclk periods, then release OV_rrst and go to READ.
- READ:
  - One byte takes 2 S_CLK cycles: phase A with OV_rclk=0, phase B with OV_rclk=1.
  - OV_data is sampled on the S_CLK edge that ends phase B.
  - Back-pressure is checked only at a 2-byte pixel boundary. While w_usedw >= AFULL, OV_rclk is held at 0 and the byte counters are frozen.
  - vs_start is ignored in READ.
- Byte order: the first byte of each pixel goes to w_data[15:8].
- mode 0: one word per pixel; H_ACT*V_ACT words per frame.
- mode 1: Y is the even byte of each YUYV pair; the first Y goes to [15:8], the second to [7:0]. One word per 2 pixels; H_ACT*V_ACT/2 words.
- mode 2: word written only when both pixel index and line index are even; (H_ACT/2)*(V_ACT/2) words. All H_ACT*V_ACT*2 bytes are still clocked out.
- w_req asserts 1 cycle after the completing byte is sampled. w_data is registered alongside it.
- Counters: byte index (1 bit), x index (0..H_ACT-1), y index (0..V_ACT-1). x wraps to 0 and y increments at end of line.
- After the final byte's word is issued: pulse frame_done, increment frame_cnt (modulo 2^16), set OV_oe=1, return to ARM. Capture rate is therefore at most one frame per two VSYNC periods.
- If the arming vs_start coincides with a reset release or with entry into ARM, it is recognised on the following cycle's evaluation; no edge is lost inside ARM.

Decomposition:
- Package ov_frame_pkg holds:
  - the state enum {BOOT, WAIT_INIT, ARM, WRITE, RRST, READ};
  - the mode constants MODE_RGB, MODE_GRAY, MODE_DEC2;
  - a function words_per_frame(mode, H_ACT, V_ACT).
- One sub-module, ov_pix_pack: takes a sampled byte, byte/x/y indices and mode_q, and produces w_data and w_req. Registered, 1-cycle latency.

Test Plan:
- Boot: release reset, init_done tied 1 → start_init pulses exactly once at cycle INIT_DLY; OV_wen stays 0 until the first vs_start.
- Capture timing: H_ACT=8, V_ACT=4, two VSYNC pulses → OV_wrst low 4 cycles then OV_wen=1 until the second edge; OV_rrst low for 4 rclk periods; 64 rclk periods follow.
- RGB565: bytes counting 0x00,0x01,… in mode 0 → 32 words 0x0001, 0x0203, …; frame_done once; frame_cnt=1.
- GRAY8: YUYV stream Y=0x10+n, U/V=0x80, mode 1 → 16 words 0x1011, 0x1213, ….
- Decimation: mode 2 → 8 words; pixels (0,0),(2,0),(4,0),(6,0),(0,2),… in that order.
- Back-pressure and reset: hold w_usedw=AFULL for 50 cycles mid-line → OV_rclk frozen low, no w_req, data sequence unbroken on resume. Then assert RST_N low mid-READ → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ov_frame_pkg.sv
// Shared types and helpers for the camera frame reader.
//   state_e          : controller states
//   MODE_*           : runtime packing modes (3 is folded onto MODE_RGB)
//   words_per_frame  : words produced by one frame in a given mode
//   norm_mode        : folds the reserved mode code onto RGB565
package ov_frame_pkg;

  typedef enum logic [2:0] {
    BOOT,
    WAIT_INIT,
    ARM,
    WRITE,
    RRST,
    READ
  } state_e;

  localparam logic [1:0] MODE_RGB  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_DEC2 = 2'd2;

  function automatic int unsigned words_per_frame(input logic [1:0]  mode,
                                                  input int unsigned h_act,
                                                  input int unsigned v_act);
    case (mode)
      MODE_GRAY: return (h_act * v_act) / 2;
      MODE_DEC2: return (h_act / 2) * (v_act / 2);
      default:   return h_act * v_act;
    endcase
  endfunction

  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_RGB : mode;
  endfunction

endpackage

// File: rtl/ov_pix_pack.sv
// Byte-to-word packer for the frame reader. One registered stage.
//   clk, rst_n : clock, async active-low reset
//   i_valid    : a byte was sampled from the camera FIFO
//   i_byte     : the sampled byte
//   i_bidx     : byte index within the pixel (0 = first byte)
//   i_x0, i_y0 : LSBs of the pixel / line index of that byte
//   i_mode     : normalised packing mode
//   o_data     : packed word, held between writes
//   o_req      : one-cycle write strobe
module ov_pix_pack
  import ov_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_bidx,
  input  logic        i_x0,
  input  logic        i_y0,
  input  logic [1:0]  i_mode,
  output logic [15:0] o_data,
  output logic        o_req
);

  logic [7:0]  r_hi;
  logic [15:0] r_data;
  logic        r_req;

  logic [7:0]  w_hi_nx;
  logic [15:0] w_data_nx;
  logic        w_req_nx;

  // Packing rules: RGB/DEC2 pair the two bytes of a pixel, GRAY pairs the Y
  // bytes (byte 0) of an even/odd pixel couple.
  always_comb begin
    w_hi_nx   = r_hi;
    w_data_nx = r_data;
    w_req_nx  = 1'b0;
    if (i_valid) begin
      if (i_mode == MODE_GRAY) begin
        if (!i_bidx) begin
          if (!i_x0) begin
            w_hi_nx = i_byte;
          end else begin
            w_data_nx = {r_hi, i_byte};
            w_req_nx  = 1'b1;
          end
        end
      end else begin
        if (!i_bidx) begin
          w_hi_nx = i_byte;
        end else if ((i_mode != MODE_DEC2) || (!i_x0 && !i_y0)) begin
          w_data_nx = {r_hi, i_byte};
          w_req_nx  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_data <= '0;
      r_req  <= 1'b0;
    end else begin
      r_hi   <= w_hi_nx;
      r_data <= w_data_nx;
      r_req  <= w_req_nx;
    end
  end

  assign o_data = r_data;
  assign o_req  = r_req;

endmodule

// File: rtl/ov_frame_reader.sv
// AL422-style camera FIFO controller: boots the sensor, captures one frame
// between two VSYNC edges, then reads it out and pushes packed words into the
// SDRAM write FIFO with almost-full back-pressure.
//   S_CLK, RST_N        : system clock, async active-low reset
//   start_init/init_done: SCCB sequencer handshake
//   mode                : packing mode, latched when a capture is armed
//   OV_*                : camera FIFO control / data
//   w_usedw, w_req, w_clk, w_data : SDRAM write-FIFO port
//   frame_done, frame_cnt         : frame completion pulse and count
module ov_frame_reader
  import ov_frame_pkg::*;
#(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned USEDW_W  = 11,
  parameter int unsigned AFULL    = 1000,
  parameter int unsigned INIT_DLY = 1024,
  parameter int unsigned WRST_CYC = 4,
  parameter int unsigned RRST_CYC = 4,
  parameter int unsigned VS_POL   = 1
) (
  input  logic               S_CLK,
  input  logic               RST_N,
  output logic               start_init,
  input  logic               init_done,
  input  logic [1:0]         mode,
  input  logic [7:0]         OV_data,
  input  logic               OV_vsync,
  output logic               OV_wrst,
  output logic               OV_rrst,
  output logic               OV_oe,
  output logic               OV_wen,
  output logic               OV_rclk,
  input  logic [USEDW_W-1:0] w_usedw,
  output logic               w_req,
  output logic               w_clk,
  output logic [15:0]        w_data,
  output logic               frame_done,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned X_W       = $clog2(H_ACT);
  localparam int unsigned Y_W       = $clog2(V_ACT);
  localparam int unsigned CNT_MAX_A = (INIT_DLY > WRST_CYC) ? INIT_DLY : WRST_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > 2 * RRST_CYC) ? CNT_MAX_A : 2 * RRST_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic        VS_IDLE   = (VS_POL == 0) ? 1'b1 : 1'b0;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start_init;
  logic             r_wrst_n;
  logic             r_rrst_n;
  logic             r_oe_n;
  logic             r_wen;
  logic             r_rclk;
  logic [1:0]       r_mode_q;
  logic             r_bidx;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_done;
  logic             r_smp_vld;
  logic             r_frame_done;
  logic [15:0]      r_frame_cnt;

  logic             r_vs_s1;
  logic             r_vs_s2;
  logic             r_vs_d;
  logic             r_vs_q;

  logic [7:0]       r_smp_byte;
  logic             r_smp_bidx;
  logic             r_smp_x0;
  logic             r_smp_y0;

  state_e           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_start_init_nx;
  logic             w_wrst_n_nx;
  logic             w_rrst_n_nx;
  logic             w_oe_n_nx;
  logic             w_wen_nx;
  logic             w_rclk_nx;
  logic [1:0]       w_mode_q_nx;
  logic             w_bidx_nx;
  logic [X_W-1:0]   w_x_nx;
  logic [Y_W-1:0]   w_y_nx;
  logic             w_done_nx;
  logic             w_smp_vld_nx;
  logic             w_frame_done_nx;
  logic [15:0]      w_frame_cnt_nx;

  logic             w_vs_start;
  logic             w_afull;

  // VSYNC synchroniser and active-edge detect.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vs_s1 <= VS_IDLE;
      r_vs_s2 <= VS_IDLE;
      r_vs_d  <= VS_IDLE;
      r_vs_q  <= 1'b0;
    end else begin
      r_vs_s1 <= OV_vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
      r_vs_q  <= w_vs_start;
    end
  end

  assign w_vs_start = (VS_POL != 0) ? (r_vs_s2 & ~r_vs_d) : (~r_vs_s2 & r_vs_d);
  assign w_afull    = (w_usedw >= USEDW_W'(AFULL));

  // Controller next-state and output logic.
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_start_init_nx = 1'b0;
    w_wrst_n_nx     = r_wrst_n;
    w_rrst_n_nx     = r_rrst_n;
    w_oe_n_nx       = r_oe_n;
    w_wen_nx        = r_wen;
    w_rclk_nx       = r_rclk;
    w_mode_q_nx     = r_mode_q;
    w_bidx_nx       = r_bidx;
    w_x_nx          = r_x;
    w_y_nx          = r_y;
    w_done_nx       = r_done;
    w_smp_vld_nx    = 1'b0;
    w_frame_done_nx = 1'b0;
    w_frame_cnt_nx  = r_frame_cnt;

    case (r_state)
      BOOT: begin
        if (r_cnt == CNT_W'(INIT_DLY - 1)) begin
          w_start_init_nx = 1'b1;
          w_cnt_nx        = '0;
          w_state_nx      = WAIT_INIT;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end

      WAIT_INIT: begin
        if (init_done) w_state_nx = ARM;
      end

      // r_vs_q catches an edge that fired on the cycle ARM was entered.
      ARM: begin
        if (w_vs_start || r_vs_q) begin
          w_mode_q_nx = norm_mode(mode);
          w_wrst_n_nx = 1'b0;
          w_cnt_nx    = '0;
          w_state_nx  = WRITE;
        end
      end

      // Write-pointer reset pulse, then write enable until the closing edge.
      WRITE: begin
        if (!r_wrst_n) begin
          if (r_cnt == CNT_W'(WRST_CYC - 1)) begin
            w_wrst_n_nx = 1'b1;
            w_wen_nx    = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        if (w_vs_start) begin
          w_wrst_n_nx = 1'b1;
          w_wen_nx    = 1'b0;
          w_oe_n_nx   = 1'b0;
          w_rrst_n_nx = 1'b0;
          w_rclk_nx   = 1'b0;
          w_cnt_nx    = '0;
          w_state_nx  = RRST;
        end
      end

      // Read-pointer reset: toggle rclk every cycle for RRST_CYC periods.
      RRST: begin
        if (r_cnt == CNT_W'(2 * RRST_CYC - 1)) begin
          w_rrst_n_nx = 1'b1;
          w_rclk_nx   = 1'b0;
          w_cnt_nx    = '0;
          w_bidx_nx   = 1'b0;
          w_x_nx      = '0;
          w_y_nx      = '0;
          w_done_nx   = 1'b0;
          w_state_nx  = READ;
        end else begin
          w_cnt_nx  = r_cnt + CNT_W'(1);
          w_rclk_nx = ~r_rclk;
        end
      end

      // rclk low = phase A, high = phase B; the byte is taken as B ends.
      // After the last byte, wait for its word to leave the packer.
      READ: begin
        if (r_done) begin
          if (r_cnt == CNT_W'(1)) begin
            w_frame_done_nx = 1'b1;
            w_frame_cnt_nx  = r_frame_cnt + 16'd1;
            w_oe_n_nx       = 1'b1;
            w_done_nx       = 1'b0;
            w_cnt_nx        = '0;
            w_state_nx      = ARM;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end else if (!r_rclk) begin
          if (r_bidx || !w_afull) w_rclk_nx = 1'b1;
        end else begin
          w_rclk_nx    = 1'b0;
          w_smp_vld_nx = 1'b1;
          if (!r_bidx) begin
            w_bidx_nx = 1'b1;
          end else begin
            w_bidx_nx = 1'b0;
            if (r_x == X_W'(H_ACT - 1)) begin
              w_x_nx = '0;
              if (r_y == Y_W'(V_ACT - 1)) begin
                w_y_nx    = '0;
                w_done_nx = 1'b1;
              end else begin
                w_y_nx = r_y + Y_W'(1);
              end
            end else begin
              w_x_nx = r_x + X_W'(1);
            end
          end
        end
      end

      default: w_state_nx = BOOT;
    endcase
  end

  // Controller state register.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= BOOT;
      r_cnt        <= '0;
      r_start_init <= 1'b0;
      r_wrst_n     <= 1'b1;
      r_rrst_n     <= 1'b1;
      r_oe_n       <= 1'b1;
      r_wen        <= 1'b0;
      r_rclk       <= 1'b0;
      r_mode_q     <= MODE_RGB;
      r_bidx       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_done       <= 1'b0;
      r_smp_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_start_init <= w_start_init_nx;
      r_wrst_n     <= w_wrst_n_nx;
      r_rrst_n     <= w_rrst_n_nx;
      r_oe_n       <= w_oe_n_nx;
      r_wen        <= w_wen_nx;
      r_rclk       <= w_rclk_nx;
      r_mode_q     <= w_mode_q_nx;
      r_bidx       <= w_bidx_nx;
      r_x          <= w_x_nx;
      r_y          <= w_y_nx;
      r_done       <= w_done_nx;
      r_smp_vld    <= w_smp_vld_nx;
      r_frame_done <= w_frame_done_nx;
      r_frame_cnt  <= w_frame_cnt_nx;
    end
  end

  // Captured byte plus the indices it belongs to, before counters advance.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_smp_byte <= '0;
      r_smp_bidx <= 1'b0;
      r_smp_x0   <= 1'b0;
      r_smp_y0   <= 1'b0;
    end else if (w_smp_vld_nx) begin
      r_smp_byte <= OV_data;
      r_smp_bidx <= r_bidx;
      r_smp_x0   <= r_x[0];
      r_smp_y0   <= r_y[0];
    end
  end

  ov_pix_pack u_pack (
    .clk    (S_CLK),
    .rst_n  (RST_N),
    .i_valid(r_smp_vld),
    .i_byte (r_smp_byte),
    .i_bidx (r_smp_bidx),
    .i_x0   (r_smp_x0),
    .i_y0   (r_smp_y0),
    .i_mode (r_mode_q),
    .o_data (w_data),
    .o_req  (w_req)
  );

  assign start_init = r_start_init;
  assign OV_wrst    = r_wrst_n;
  assign OV_rrst    = r_rrst_n;
  assign OV_oe      = r_oe_n;
  assign OV_wen     = r_wen;
  assign OV_rclk    = r_rclk;
  assign w_clk      = S_CLK;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov_frame_reader.sv
// Bench for ov_frame_reader: camera FIFO model, queue scoreboard and monitor.
module tb_ov_frame_reader;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int NB    = 2 * H * V;
  localparam int PW    = $clog2(NB);
  localparam int AF    = 1000;
  localparam int INIT  = 20;
  localparam int WRSTC = 4;
  localparam int RRSTC = 4;

  logic        S_CLK;
  logic        RST_N;
  logic        start_init;
  logic        init_done;
  logic [1:0]  mode;
  logic [7:0]  OV_data;
  logic        OV_vsync;
  logic        OV_wrst;
  logic        OV_rrst;
  logic        OV_oe;
  logic        OV_wen;
  logic        OV_rclk;
  logic [10:0] w_usedw;
  logic        w_req;
  logic        w_clk;
  logic [15:0] w_data;
  logic        frame_done;
  logic [15:0] frame_cnt;

  ov_frame_reader #(
    .H_ACT(H), .V_ACT(V), .USEDW_W(11), .AFULL(AF), .INIT_DLY(INIT),
    .WRST_CYC(WRSTC), .RRST_CYC(RRSTC), .VS_POL(1)
  ) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .start_init(start_init), .init_done(init_done),
    .mode(mode), .OV_data(OV_data), .OV_vsync(OV_vsync), .OV_wrst(OV_wrst),
    .OV_rrst(OV_rrst), .OV_oe(OV_oe), .OV_wen(OV_wen), .OV_rclk(OV_rclk),
    .w_usedw(w_usedw), .w_req(w_req), .w_clk(w_clk), .w_data(w_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Camera FIFO model: read pointer cleared by rclk while rrst is low,
  // first rclk after release presents byte 0, each further rclk advances.
  logic [7:0]    mem [NB];
  logic [PW-1:0] rd_ptr = '0;
  bit            rd_first = 1'b1;

  always @(posedge OV_rclk) begin
    if (!OV_rrst) begin
      rd_ptr   = '0;
      rd_first = 1'b1;
    end else if (rd_first) begin
      rd_first = 1'b0;
    end else begin
      rd_ptr = rd_ptr + PW'(1);
    end
  end
  assign OV_data = mem[rd_ptr];

  // Reference model: expected word stream derived from frame contents.
  logic [15:0] exp_q [$];

  task automatic push_expected(input int m);
    int mm;
    int p;
    mm = (m == 3) ? 0 : m;
    if (mm == 0) begin
      for (int i = 0; i < H * V; i++) exp_q.push_back({mem[2 * i], mem[2 * i + 1]});
    end else if (mm == 1) begin
      for (int q = 0; q < H * V / 2; q++) exp_q.push_back({mem[4 * q], mem[4 * q + 2]});
    end else begin
      for (int y = 0; y < V; y += 2)
        for (int x = 0; x < H; x += 2) begin
          p = y * H + x;
          exp_q.push_back({mem[2 * p], mem[2 * p + 1]});
        end
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int i = 0; i < NB; i++) begin
      if (kind == 0)      mem[i] = 8'(i);
      else if (kind == 1) mem[i] = (i % 2 == 0) ? 8'(16 + i / 2) : 8'h80;
      else                mem[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Monitor: scoreboard pop on w_req, per-frame timing statistics.
  int  words_seen = 0;
  int  frames_seen = 0;
  int  wrst_len = 0;
  int  rrst_rclk = 0;
  int  read_rclk = 0;
  int  read_cyc = 0;
  int  wen_early = 0;
  bit  vs_issued = 1'b0;
  bit  bp_frame = 1'b0;
  bit  p_wrst = 1'b1;
  bit  p_rclk = 1'b0;
  logic [15:0] e;

  always @(negedge S_CLK) begin
    if (!RST_N) begin
      p_wrst = 1'b1;
      p_rclk = 1'b0;
    end else begin
      if (w_req) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(w_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'(w_data), 32'(e));
        end
      end
      if (!OV_wrst) begin
        if (p_wrst) begin
          wrst_len  = 1;
          rrst_rclk = 0;
          read_rclk = 0;
          read_cyc  = 0;
        end else begin
          wrst_len++;
        end
      end
      if (OV_wrst && !p_wrst) begin
        chk("wrst_len", wrst_len, WRSTC);
        chk("wen_after_wrst", 32'(OV_wen), 1);
      end
      if (OV_rclk && !p_rclk) begin
        if (!OV_rrst) begin
          rrst_rclk++;
          chk("oe_in_rrst", 32'(OV_oe), 0);
        end else if (!OV_oe) begin
          read_rclk++;
        end
      end
      if (!OV_oe && OV_rrst) read_cyc++;
      if (OV_wen && !vs_issued) wen_early++;
      if (frame_done) begin
        frames_seen++;
        chk("words_left", exp_q.size(), 0);
        chk("frame_cnt", 32'(frame_cnt), frames_seen);
        chk("rrst_periods", rrst_rclk, RRSTC);
        chk("read_periods", read_rclk, NB);
        chk("wen_off", 32'(OV_wen), 0);
        if (!bp_frame) begin
          chk("read_cyc_min", 32'(read_cyc >= 2 * NB), 1);
          chk("read_cyc_max", 32'(read_cyc <= 2 * NB + 4), 1);
        end
      end
      p_wrst = OV_wrst;
      p_rclk = OV_rclk;
    end
  end

  task automatic vs_pulse();
    vs_issued = 1'b1;
    @(posedge S_CLK); #2 OV_vsync = 1'b1;
    repeat (4) @(posedge S_CLK);
    #2 OV_vsync = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 5000; i++) begin
      if (words_seen >= n) break;
      @(posedge S_CLK);
    end
    chk("words_reached", 32'(words_seen >= n), 1);
  endtask

  task automatic wait_frame(input int n);
    for (int i = 0; i < 5000; i++) begin
      if (frames_seen >= n) break;
      @(posedge S_CLK);
    end
    chk("frame_reached", frames_seen, n);
  endtask

  task automatic check_reset_vals();
    chk("rst_start_init", 32'(start_init), 0);
    chk("rst_wrst", 32'(OV_wrst), 1);
    chk("rst_rrst", 32'(OV_rrst), 1);
    chk("rst_oe", 32'(OV_oe), 1);
    chk("rst_wen", 32'(OV_wen), 0);
    chk("rst_rclk", 32'(OV_rclk), 0);
    chk("rst_w_req", 32'(w_req), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
  endtask

  task automatic boot_check();
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    @(negedge S_CLK);
    RST_N = 1'b1;
    for (int c = 1; c <= INIT + 8; c++) begin
      @(posedge S_CLK); #1;
      if (start_init) begin
        pulses++;
        at = c;
      end
    end
    chk("start_init_pulses", pulses, 1);
    chk("start_init_cycle", at, INIT);
  endtask

  task automatic run_frame(input int m, input int kind, input bit bp,
                           input bit inj, input bit rst);
    int base;
    int tgt;
    int viol;
    fill_mem(kind);
    push_expected(m);
    mode = 2'(m);
    bp_frame = bp;
    tgt = frames_seen + 1;
    vs_pulse();
    repeat (40) @(posedge S_CLK);
    vs_pulse();
    base = words_seen;
    if (bp) begin
      wait_words(base + 5);
      @(posedge S_CLK); #2 w_usedw = 11'(AF);
      viol = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge S_CLK);
        if (i >= 6 && (OV_rclk || w_req)) viol++;
      end
      chk("bp_hold", viol, 0);
      @(posedge S_CLK); #2 w_usedw = 11'($urandom_range(0, AF - 1));
    end
    if (inj) begin
      wait_words(base + 6);
      vs_pulse();
    end
    if (rst) begin
      wait_words(base + 5);
      @(negedge S_CLK); #2 RST_N = 1'b0;
      #1 check_reset_vals();
      exp_q.delete();
      return;
    end
    wait_frame(tgt);
  endtask

  initial begin
    RST_N     = 1'b0;
    init_done = 1'b1;
    mode      = 2'd0;
    OV_vsync  = 1'b0;
    w_usedw   = '0;
    repeat (3) @(posedge S_CLK);
    #1 check_reset_vals();
    boot_check();
    @(negedge S_CLK);
    chk("w_clk_fwd", 32'(w_clk), 0);

    run_frame(0, 0, 1'b0, 1'b0, 1'b0);
    w_usedw = 11'(AF - 1);
    run_frame(1, 1, 1'b0, 1'b0, 1'b0);
    w_usedw = 11'($urandom_range(0, AF - 1));
    run_frame(2, 2, 1'b0, 1'b1, 1'b0);
    run_frame(3, 2, 1'b1, 1'b0, 1'b0);
    run_frame(int'($urandom_range(0, 2)), 2, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge S_CLK);
    boot_check();
    repeat (10) @(posedge S_CLK);
    chk("wen_early", wen_early, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
